// File: rtl/lsu_pkg.sv
// Shared types for the M-stage load/store sequencer.
// Optional misaligned split support: LSU_MISALIGN_SPLIT_EN.
package lsu_pkg;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;

  localparam logic [7:0] MASK_BYTE = 8'h01;
  localparam logic [7:0] MASK_HALF = 8'h03;
  localparam logic [7:0] MASK_WORD = 8'h0f;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    DONE
  } state_e;

  function automatic logic [1:0] norm_mode(
    input logic [1:0] m
  );
    return (m == 2'b11) ? MODE_WORD : m;
  endfunction

  // An access is misaligned exactly when it crosses a word boundary.
  function automatic logic is_misaligned(
    input logic [1:0] m,
    input logic [1:0] off
  );
    return ((m == MODE_HALF) && (off == 2'd3)) ||
           ((m == MODE_WORD) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane shifter: store window, byte enables and load extension.
// Combinational only; mode is expected already normalised.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [7:0]  be,
  output logic [63:0] wide,
  output logic [31:0] ldata
);

  logic [4:0]  sh_amt;
  logic [7:0]  mask;
  logic [63:0] rd64;
  logic [31:0] sh;

  assign sh_amt = {off, 3'b000};
  assign wide   = {32'b0, wdata} << sh_amt;
  assign rd64   = {hi, lo} >> sh_amt;
  assign sh     = rd64[31:0];
  assign be     = mask << off;

  always_comb begin
    mask  = MASK_WORD;
    ldata = sh;
    unique case (1'b1)
      mode == MODE_BYTE: begin
        mask  = MASK_BYTE;
        ldata = {{24{~uns & sh[7]}}, sh[7:0]};
      end
      mode == MODE_HALF: begin
        mask  = MASK_HALF;
        ldata = {{16{~uns & sh[15]}}, sh[15:0]};
      end
      default: begin
        mask  = MASK_WORD;
        ldata = sh;
      end
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// M-stage load/store sequencer driving a req/ack word bus.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses in two beats.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        mem_write,
  input  logic [1:0]  mem_mode,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misaligned_err,
  output logic        timeout_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [15:0] TO_LAST =
    16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e      state;
  logic        mw_q;
  logic        uns_q;
  logic [1:0]  mode_q;
  logic [1:0]  off_q;
  logic [15:0] cnt;

  logic        idle;
  logic [1:0]  mode_n;
  logic [1:0]  mode_s;
  logic [1:0]  off_s;
  logic        req_mis;
  logic [7:0]  be8;
  logic [63:0] wide;
  logic [31:0] ldata;
  logic [31:0] lo_s;
  logic [31:0] hi_s;
  logic        beat;
  logic        last;
  logic        to_hit;
  logic        done_ok;
  logic        tmo;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        mis_q;
  logic [3:0]  be_hi_q;
  logic [31:0] wd_hi_q;
  logic [31:0] hold_q;
  logic        next_beat;

  assign last      = (state == BEAT1) || !mis_q;
  assign lo_s      = (state == BEAT1) ? hold_q : bus_rdata;
  assign hi_s      = bus_rdata;
  assign next_beat = beat && bus_ack && !last;
`else
  logic        unused_hi;

  assign last      = 1'b1;
  assign lo_s      = bus_rdata;
  assign hi_s      = 32'b0;
  assign unused_hi = ^{wide[63:32], be8[7:4]};
`endif

  assign idle    = (state == IDLE);
  assign mode_n  = norm_mode(mem_mode);
  assign mode_s  = idle ? mode_n : mode_q;
  assign off_s   = idle ? addr[1:0] : off_q;
  assign req_mis = is_misaligned(mode_n, addr[1:0]);
  assign stall   = idle ? req_valid : (state != DONE);

  assign beat    = ((state == BEAT0) || (state == BEAT1)) && bus_req;
  assign to_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign done_ok = beat && bus_ack && last;
  assign tmo     = beat && !bus_ack && to_hit;

  lsu_lane_align u_align (
    .mode  (mode_s),
    .off   (off_s),
    .uns   (uns_q),
    .wdata (wdata),
    .lo    (lo_s),
    .hi    (hi_s),
    .be    (be8),
    .wide  (wide),
    .ldata (ldata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_be         <= '0;
      bus_wdata      <= '0;
      resp_valid     <= 1'b0;
      rdata          <= '0;
      misaligned_err <= 1'b0;
      timeout_err    <= 1'b0;
      cnt            <= '0;
      mw_q           <= 1'b0;
      uns_q          <= 1'b0;
      mode_q         <= MODE_BYTE;
      off_q          <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      mis_q          <= 1'b0;
      be_hi_q        <= '0;
      wd_hi_q        <= '0;
      hold_q         <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            mw_q   <= mem_write;
            uns_q  <= load_unsigned;
            mode_q <= mode_n;
            off_q  <= addr[1:0];
            cnt    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            mis_q   <= req_mis;
            be_hi_q <= be8[7:4];
            wd_hi_q <= wide[63:32];
`else
            if (req_mis) begin
              state          <= DONE;
              resp_valid     <= 1'b1;
              misaligned_err <= 1'b1;
            end else
`endif
            begin
              state     <= BEAT0;
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= be8[3:0];
              bus_wdata <= wide[31:0];
            end
          end
        end
        BEAT0, BEAT1: begin
          cnt <= (bus_ack || to_hit) ? '0 : cnt + 16'd1;
        end
        DONE: begin
          state          <= IDLE;
          resp_valid     <= 1'b0;
          rdata          <= '0;
          misaligned_err <= 1'b0;
          timeout_err    <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Completion or timeout: release the bus and report.
      if (done_ok || tmo) begin
        state       <= DONE;
        resp_valid  <= 1'b1;
        timeout_err <= tmo;
        rdata       <= (tmo || mw_q) ? '0 : ldata;
        bus_req     <= 1'b0;
        bus_we      <= 1'b0;
        bus_addr    <= '0;
        bus_be      <= '0;
        bus_wdata   <= '0;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (next_beat) begin
        state     <= BEAT1;
        hold_q    <= bus_rdata;
        bus_addr  <= bus_addr + 32'd4;
        bus_be    <= be_hi_q;
        bus_wdata <= wd_hi_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Self-checking bench for lsu_sequencer with a byte-level reference model.
// Honours LSU_MISALIGN_SPLIT_EN in its expectations.
module tb_lsu_sequencer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_mode = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stall, resp_valid, misaligned_err, timeout_err;
  logic        bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int total = 0;
  int bad = 0;

  int          ob_n, ob_req_cyc, ob_lat;
  bit          ob_got, ob_unstable, ob_stall_bad;
  logic        ob_mis, ob_tmo, ob_after_resp, ob_after_stall, ob_after_req;
  logic [31:0] ob_rdata;
  logic [31:0] ob_addr [2];
  logic [3:0]  ob_be [2];
  logic [31:0] ob_wd [2];
  logic        ob_we [2];

  int          ex_n, ex_lat;
  logic        ex_mis;
  logic [31:0] ex_rdata;
  logic [31:0] ex_addr [2];
  logic [31:0] ex_wd [2];
  logic [3:0]  ex_be [2];

  always #5 clk = ~clk;

  lsu_sequencer #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .mem_write      (mem_write),
    .mem_mode       (mem_mode),
    .load_unsigned  (load_unsigned),
    .addr           (addr),
    .wdata          (wdata),
    .stall          (stall),
    .resp_valid     (resp_valid),
    .rdata          (rdata),
    .misaligned_err (misaligned_err),
    .timeout_err    (timeout_err),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_be         (bus_be),
    .bus_wdata      (bus_wdata),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata)
  );

  // Byte-lane reference: walks each byte of the access individually.
  task automatic ref_model(
    input logic w, input logic [1:0] m, input logic u,
    input logic [31:0] a, d, r0, r1, input int dly
  );
    int size, off, l;
    logic [31:0] word;
    longint val;
    size = (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    ex_mis = 1'b0;
    ex_rdata = '0;
    for (int b = 0; b < 2; b++) begin
      ex_addr[b] = (a & ~32'd3) + 32'(4 * b);
      ex_be[b] = '0;
      ex_wd[b] = '0;
    end
    ex_n = 1;
    if (off + size > 4) begin
`ifdef LSU_MISALIGN_SPLIT_EN
      ex_n = 2;
`else
      ex_n = 0;
      ex_mis = 1'b1;
      ex_lat = 1;
      return;
`endif
    end
    ex_lat = ex_n * (dly + 1) + 1;
    for (int i = 0; i < 4; i++) begin
      l = off + i;
      ex_wd[l / 4][8 * (l % 4) +: 8] = d[8 * i +: 8];
      if (i < size) ex_be[l / 4][l % 4] = 1'b1;
    end
    val = 0;
    for (int i = 0; i < size; i++) begin
      l = off + i;
      word = (l < 4) ? r0 : r1;
      val += longint'(word[8 * (l % 4) +: 8]) << (8 * i);
    end
    if (!u && size < 4 && val >= (longint'(1) << (8 * size - 1)))
      val -= longint'(1) << (8 * size);
    ex_rdata = w ? 32'd0 : val[31:0];
  endtask

  // Bus responder: drives one request and records what the DUT did.
  task automatic do_access(
    input logic w, input logic [1:0] m, input logic u,
    input logic [31:0] a, d, r0, r1, input int dly, input bit noack
  );
    int wc;
    bit inbeat;
    ob_n = 0; ob_req_cyc = 0; ob_lat = 0; ob_got = 0;
    ob_unstable = 0; ob_stall_bad = 0;
    ob_rdata = 'x; ob_mis = 1'bx; ob_tmo = 1'bx;
    wc = 0; inbeat = 0;
    @(negedge clk);
    req_valid = 1'b1; mem_write = w; mem_mode = m;
    load_unsigned = u; addr = a; wdata = d;
    #1;
    if (stall !== 1'b1) ob_stall_bad = 1;
    for (int c = 1; c <= 60 && !ob_got; c++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      if (resp_valid === 1'b1) begin
        ob_got = 1; ob_lat = c;
        ob_rdata = rdata; ob_mis = misaligned_err; ob_tmo = timeout_err;
        if (stall !== 1'b0) ob_stall_bad = 1;
        req_valid = 1'b0;
      end else begin
        if (stall !== 1'b1) ob_stall_bad = 1;
        if (bus_req === 1'b1) begin
          ob_req_cyc++;
          if (!inbeat) begin
            if (ob_n < 2) begin
              ob_addr[ob_n] = bus_addr; ob_be[ob_n] = bus_be;
              ob_wd[ob_n] = bus_wdata; ob_we[ob_n] = bus_we;
            end
            ob_n++; inbeat = 1; wc = 0;
          end else if (ob_n <= 2) begin
            if (bus_addr !== ob_addr[ob_n-1] || bus_be !== ob_be[ob_n-1] ||
                bus_wdata !== ob_wd[ob_n-1] || bus_we !== ob_we[ob_n-1])
              ob_unstable = 1;
          end
          if (!noack && wc == dly) begin
            bus_ack = 1'b1;
            bus_rdata = (ob_n == 1) ? r0 : r1;
            inbeat = 0;
          end else wc++;
        end
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    bus_ack = 1'b0;
    ob_after_resp = resp_valid; ob_after_stall = stall; ob_after_req = bus_req;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_bus_req got=%b exp=0", bus_req); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp got=%b exp=0", resp_valid); end
    total++; if ({bus_addr, bus_wdata, rdata} !== 96'd0) begin bad++; $display("FAIL rst_data got=%h/%h/%h exp=0", bus_addr, bus_wdata, rdata); end
    total++; if ({bus_be, bus_we, misaligned_err, timeout_err} !== 7'd0) begin bad++; $display("FAIL rst_flags got=%b%b%b%b exp=0", bus_be, bus_we, misaligned_err, timeout_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    // sb at offset 3, immediate ack
    do_access(1'b1, 2'b00, 1'b0, 32'h1003, 32'h0000_00ab, 0, 0, 0, 0);
    total++; if (ob_n !== 1 || ob_addr[0] !== 32'h1000) begin bad++; $display("FAIL sb_addr got=%0d/%h exp=1/00001000", ob_n, ob_addr[0]); end
    total++; if (ob_be[0] !== 4'b1000 || ob_we[0] !== 1'b1) begin bad++; $display("FAIL sb_be got=%b we=%b exp=1000 we=1", ob_be[0], ob_we[0]); end
    total++; if (ob_wd[0] !== 32'hab00_0000) begin bad++; $display("FAIL sb_wdata got=%h exp=ab000000", ob_wd[0]); end
    total++; if (ob_lat !== 2 || ob_rdata !== 32'd0) begin bad++; $display("FAIL sb_resp got=lat%0d/%h exp=lat2/0", ob_lat, ob_rdata); end
    // lh signed then unsigned
    do_access(1'b0, 2'b01, 1'b0, 32'h2002, 0, 32'h8001_1234, 0, 1, 0);
    total++; if (ob_rdata !== 32'hffff_8001) begin bad++; $display("FAIL lh_signed got=%h exp=ffff8001", ob_rdata); end
    total++; if (ob_be[0] !== 4'b1100 || ob_lat !== 3) begin bad++; $display("FAIL lh_be got=%b lat%0d exp=1100 lat3", ob_be[0], ob_lat); end
    do_access(1'b0, 2'b01, 1'b1, 32'h2002, 0, 32'h8001_1234, 0, 0, 0);
    total++; if (ob_rdata !== 32'h0000_8001) begin bad++; $display("FAIL lhu got=%h exp=00008001", ob_rdata); end
    // misaligned lw
    do_access(1'b0, 2'b10, 1'b0, 32'h3001, 0, 32'h4433_2211, 32'h8877_6655, 0, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
    total++; if (ob_n !== 2 || ob_addr[0] !== 32'h3000 || ob_addr[1] !== 32'h3004) begin bad++; $display("FAIL lw_mis_addr got=%0d %h %h exp=2 3000 3004", ob_n, ob_addr[0], ob_addr[1]); end
    total++; if (ob_be[0] !== 4'b1110 || ob_be[1] !== 4'b0001) begin bad++; $display("FAIL lw_mis_be got=%b %b exp=1110 0001", ob_be[0], ob_be[1]); end
    total++; if (ob_rdata !== 32'h5544_3322 || ob_mis !== 1'b0) begin bad++; $display("FAIL lw_mis_data got=%h err=%b exp=55443322 err=0", ob_rdata, ob_mis); end
    do_access(1'b1, 2'b10, 1'b0, 32'hffff_fffe, 32'hddcc_bbaa, 0, 0, 1, 0);
    total++; if (ob_addr[0] !== 32'hffff_fffc || ob_be[0] !== 4'b1100 || ob_wd[0] !== 32'hbbaa_0000) begin bad++; $display("FAIL sw_wrap_b0 got=%h %b %h exp=fffffffc 1100 bbaa0000", ob_addr[0], ob_be[0], ob_wd[0]); end
    total++; if (ob_addr[1] !== 32'h0 || ob_be[1] !== 4'b0011 || ob_wd[1] !== 32'h0000_ddcc) begin bad++; $display("FAIL sw_wrap_b1 got=%h %b %h exp=00000000 0011 0000ddcc", ob_addr[1], ob_be[1], ob_wd[1]); end
`else
    total++; if (ob_req_cyc !== 0 || ob_n !== 0) begin bad++; $display("FAIL lw_mis_nobus got=%0d req cycles exp=0", ob_req_cyc); end
    total++; if (ob_mis !== 1'b1 || ob_rdata !== 32'd0 || ob_lat !== 1) begin bad++; $display("FAIL lw_mis_resp got=err%b %h lat%0d exp=err1 0 lat1", ob_mis, ob_rdata, ob_lat); end
    do_access(1'b1, 2'b10, 1'b0, 32'hffff_fffe, 32'hddcc_bbaa, 0, 0, 1, 0);
    total++; if (ob_req_cyc !== 0 || ob_mis !== 1'b1) begin bad++; $display("FAIL sw_mis got=req%0d err%b exp=req0 err1", ob_req_cyc, ob_mis); end
`endif
  endtask

  task automatic test_stall_hold();
    do_access(1'b0, 2'b10, 1'b0, 32'h4000, 0, 32'hcafe_f00d, 0, 5, 0);
    total++; if (ob_unstable || ob_stall_bad) begin bad++; $display("FAIL hold_stable got=unstable%0d stallbad%0d exp=0/0", ob_unstable, ob_stall_bad); end
    total++; if (ob_req_cyc !== 6 || ob_lat !== 7) begin bad++; $display("FAIL hold_timing got=req%0d lat%0d exp=req6 lat7", ob_req_cyc, ob_lat); end
    total++; if (ob_rdata !== 32'hcafe_f00d || ob_tmo !== 1'b0) begin bad++; $display("FAIL hold_data got=%h tmo%b exp=cafef00d tmo0", ob_rdata, ob_tmo); end
    total++; if (ob_after_resp !== 1'b0 || ob_after_stall !== 1'b0) begin bad++; $display("FAIL hold_pulse got=resp%b stall%b exp=0/0", ob_after_resp, ob_after_stall); end
  endtask

  task automatic test_timeout();
    do_access(1'b0, 2'b10, 1'b0, 32'h4000, 0, 32'h1234_5678, 0, 0, 1);
    total++; if (ob_got !== 1'b1 || ob_tmo !== 1'b1) begin bad++; $display("FAIL tmo_flag got=resp%0d tmo%b exp=1/1", ob_got, ob_tmo); end
    total++; if (ob_req_cyc !== TO || ob_lat !== TO + 1) begin bad++; $display("FAIL tmo_timing got=req%0d lat%0d exp=req%0d lat%0d", ob_req_cyc, ob_lat, TO, TO + 1); end
    total++; if (ob_rdata !== 32'd0 || ob_after_req !== 1'b0) begin bad++; $display("FAIL tmo_rdata got=%h req%b exp=0 req0", ob_rdata, ob_after_req); end
    do_access(1'b0, 2'b10, 1'b0, 32'h4000, 0, 32'h0bad_beef, 0, TO - 2, 0);
    total++; if (ob_tmo !== 1'b0 || ob_rdata !== 32'h0bad_beef || ob_lat !== TO) begin bad++; $display("FAIL tmo_recover got=tmo%b %h lat%0d exp=tmo0 0badbeef lat%0d", ob_tmo, ob_rdata, ob_lat, TO); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; mem_write = 1'b0; mem_mode = 2'b10; addr = 32'h4000;
    @(negedge clk);
    total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rmid_start got=%b exp=1", bus_req); end
    rst_n = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    total++; if (bus_req !== 1'b0 || stall !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL rmid_abort got=req%b stall%b resp%b exp=000", bus_req, stall, resp_valid); end
    rst_n = 1'b1; bus_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus_req !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL rmid_idle got=req%b resp%b exp=00", bus_req, resp_valid); end
    end
    bus_ack = 1'b0;
    do_access(1'b0, 2'b00, 1'b0, 32'h4001, 0, 32'h0000_9a00, 0, 0, 0);
    total++; if (ob_rdata !== 32'hffff_ff9a || ob_lat !== 2) begin bad++; $display("FAIL rmid_after got=%h lat%0d exp=ffffff9a lat2", ob_rdata, ob_lat); end
  endtask

  task automatic test_random();
    logic w, u;
    logic [1:0] m;
    logic [31:0] a, d, r0, r1;
    int dly;
    for (int k = 0; k < 40; k++) begin
      w = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
      m = 2'($urandom_range(0, 3)); a = $urandom; d = $urandom;
      r0 = $urandom; r1 = $urandom; dly = $urandom_range(0, 3);
      ref_model(w, m, u, a, d, r0, r1, dly);
      do_access(w, m, u, a, d, r0, r1, dly, 0);
      total++; if (ob_got !== 1'b1 || ob_lat !== ex_lat) begin bad++; $display("FAIL rnd%0d_lat got=%0d exp=%0d", k, ob_lat, ex_lat); end
      total++; if (ob_n !== ex_n) begin bad++; $display("FAIL rnd%0d_beats got=%0d exp=%0d", k, ob_n, ex_n); end
      total++; if (ob_rdata !== ex_rdata) begin bad++; $display("FAIL rnd%0d_rdata got=%h exp=%h", k, ob_rdata, ex_rdata); end
      total++; if (ob_mis !== ex_mis || ob_tmo !== 1'b0) begin bad++; $display("FAIL rnd%0d_err got=mis%b tmo%b exp=mis%b tmo0", k, ob_mis, ob_tmo, ex_mis); end
      total++; if (ob_unstable || ob_stall_bad || ob_after_resp !== 1'b0) begin bad++; $display("FAIL rnd%0d_hs got=%0d%0d%b exp=000", k, ob_unstable, ob_stall_bad, ob_after_resp); end
      for (int b = 0; b < ex_n && b < ob_n && b < 2; b++) begin
        total++; if (ob_addr[b] !== ex_addr[b] || ob_be[b] !== ex_be[b] || ob_we[b] !== w) begin bad++; $display("FAIL rnd%0d_b%0d got=%h %b we%b exp=%h %b we%b", k, b, ob_addr[b], ob_be[b], ob_we[b], ex_addr[b], ex_be[b], w); end
        if (w) begin
          total++; if (ob_wd[b] !== ex_wd[b]) begin bad++; $display("FAIL rnd%0d_wd%0d got=%h exp=%h", k, b, ob_wd[b], ex_wd[b]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_hold();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
